jellyvl_synctimer_timer_slew: RTL and testbench
===============================================

Name: jellyvl_synctimer_timer_slew

Overview:
Free-running synchronised time counter. It advances by the rational rate NUMERATOR/DENOMINATOR per clock.
- Extends the ±1-per-cycle adjust timer: accepts a signed multi-unit correction and slews it in, at most MAX_STEP per cycle, without ever stepping time backwards.
- Sits between the synctimer core/PI controller and timestamp consumers.

Parameters:
- NUMERATOR, 10: time units per DENOMINATOR clocks.
- DENOMINATOR, 3: clock count for the rational rate; ≥1.
- TIMER_WIDTH, 64: width of current_time and set_time.
- ADJUST_WIDTH, 16: width of the signed correction request (two's complement).
- MAX_STEP, 1: maximum correction applied per cycle. Elaboration error if MAX_STEP = 0 or MAX_STEP > NUMERATOR/DENOMINATOR.

Ports:
- reset, input, 1: synchronous reset, active high.
- clk, input, 1: single clock; all logic on posedge.
- set_time, input, TIMER_WIDTH: absolute time to load.
- set_valid, input, 1: load strobe; no ready, always accepted.
- adjust_value, input, ADJUST_WIDTH: signed correction in time units.
- adjust_valid, input, 1: correction request.
- adjust_ready, output, 1: high when no correction is pending; transfer happens on valid&&ready.
- adjust_busy, output, 1: equals !adjust_ready.
- adjust_remain, output, ADJUST_WIDTH: signed remaining correction.
- current_time, output, TIMER_WIDTH: time value.

Behaviour:
- Constants:
  - COUNT_NUM = NUMERATOR/DENOMINATOR; COUNT_ERR = NUMERATOR%DENOMINATOR.
  - Increment register width = clog2(COUNT_NUM+MAX_STEP+2), minimum 1.
- Reset values: current_time=0, add_value=0, err=0, pending=0, adjust_ready=1, adjust_busy=0, adjust_remain=0.
- Fractional accumulator (COUNT_ERR≠0 only):
  - carry = err ≥ DENOMINATOR−COUNT_ERR.
  - On carry: err −= DENOMINATOR−COUNT_ERR. Otherwise: err += COUNT_ERR.
  - base = COUNT_NUM + carry.
  - When COUNT_ERR=0 the accumulator is absent and base = COUNT_NUM.
- Slew FSM (IDLE/SLEW):
  - IDLE, adjust_valid=1, adjust_value≠0: pending ← adjust_value; go to SLEW.
  - adjust_value=0 is accepted and stays in IDLE.
  - SLEW, each cycle: step = min(|pending|, MAX_STEP).
    - add_value ← base + step if pending>0, base − step if pending<0.
    - pending moves toward 0 by step.
    - pending reaching 0 → IDLE.
  - Outside SLEW: add_value ← base.
- adjust_ready is registered state (pending==0), not combinational on adjust_valid. Requests while busy are held by the master.
- Most-negative adjust_value: magnitude is computed at ADJUST_WIDTH+1 bits; no overflow.
- Timer update:
  - Default: current_time ← current_time + add_value.
  - set_valid: current_time ← set_time + add_value.
  - Wraps modulo 2^TIMER_WIDTH.
- Latency:
  - A base or step decision appears in current_time one cycle after add_value registers it.
  - First post-reset cycle adds 0.
- Reset mid-slew: pending is discarded, FSM returns to IDLE.

Optional Feature:
JELLYVL_SYNCTIMER_SLEW_ABORT_EN
- Defined: set_valid clears pending and forces IDLE. An adjust accepted in the same cycle as set_valid is still loaded; load takes priority over clear.
- Undefined: set_valid only loads time, and any pending slew continues unchanged.

Decomposition:
- Package jellyvl_synctimer_pkg: COUNT_NUM/COUNT_ERR helper functions, the slew state enum, and the step-magnitude function.
- Sub-module jellyvl_synctimer_frac_step: Bresenham accumulator with inputs NUMERATOR/DENOMINATOR and output carry. It is reused by later rate generators.

Test Plan:
- Defaults, no adjust: steady-state add_value sequence is 3,3,4 repeating; current_time advances exactly 100 over any 30 consecutive cycles.
- adjust_value=+5, MAX_STEP=1: adjust_ready low for exactly 5 cycles; adjust_remain 5→0; current_time advance over the 15-cycle window containing the slew = 55.
- adjust_value=−7, MAX_STEP=2 (NUMERATOR=30, DENOMINATOR=3): applied steps are 2,2,2,1; current_time increments are never below 8; total deficit = 7.
- set_valid with set_time=0x1000 while IDLE: next current_time = 0x1000 + add_value. Set mid-slew with the macro on: adjust_remain goes to 0 next cycle. With the macro off: the slew completes.
- adjust_valid held high during a slew: no second acceptance until adjust_ready rises; adjust_value=0 accepted with no time change. current_time=2^64−2 with increment 3 wraps to 1.
- Reset asserted mid-slew: all outputs return to their reset values the next cycle; after release the 3,3,4 cadence restarts from err=0.

Source files
------------

// File: rtl/jellyvl_synctimer_pkg.sv
// ============================================================================
//  Module      : jellyvl_synctimer_pkg
//  Description : Shared rate helpers, slew state encoding and step limiter
//                for the synchronised timer family.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jellyvl_synctimer_pkg;

    typedef enum logic [0:0] {
        SLEW_IDLE   = 1'b0,
        SLEW_ACTIVE = 1'b1
    } slew_state_t;

    // Whole time units advanced per clock.
    function automatic int unsigned count_num(input int unsigned num, input int unsigned den);
        return num / den;
    endfunction

    // Fractional remainder spread over DENOMINATOR clocks.
    function automatic int unsigned count_err(input int unsigned num, input int unsigned den);
        return num % den;
    endfunction

    // Correction applied this cycle: the outstanding magnitude, capped at max_step.
    function automatic logic [63:0] step_mag(input logic [63:0] mag, input logic [63:0] max_step);
        return (mag < max_step) ? mag : max_step;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jellyvl_synctimer_timer_slew_if.sv
// ============================================================================
//  Module      : jellyvl_synctimer_timer_slew_if
//  Description : Time load / correction request bus and timer outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface jellyvl_synctimer_timer_slew_if #(
    parameter int unsigned TIMER_WIDTH  = 64,
    parameter int unsigned ADJUST_WIDTH = 16
);
    logic        [TIMER_WIDTH-1:0]  set_time;
    logic                           set_valid;
    logic signed [ADJUST_WIDTH-1:0] adjust_value;
    logic                           adjust_valid;
    logic                           adjust_ready;
    logic                           adjust_busy;
    logic signed [ADJUST_WIDTH-1:0] adjust_remain;
    logic        [TIMER_WIDTH-1:0]  current_time;

    modport master (
        output set_time, set_valid, adjust_value, adjust_valid,
        input  adjust_ready, adjust_busy, adjust_remain, current_time
    );

    modport slave (
        input  set_time, set_valid, adjust_value, adjust_valid,
        output adjust_ready, adjust_busy, adjust_remain, current_time
    );
endinterface

`default_nettype wire

// File: rtl/jellyvl_synctimer_frac_step.sv
// ============================================================================
//  Module      : jellyvl_synctimer_frac_step
//  Description : Bresenham accumulator; carry_o marks the cycles that take
//                one extra unit so the long-run rate is NUMERATOR/DENOMINATOR.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jellyvl_synctimer_frac_step
    import jellyvl_synctimer_pkg::*;
#(
    parameter int unsigned NUMERATOR   = 10,
    parameter int unsigned DENOMINATOR = 3
) (
    input  wire logic clk,
    input  wire logic reset,
    output logic      carry_o
);
    localparam int unsigned COUNT_ERR = count_err(NUMERATOR, DENOMINATOR);

    if (COUNT_ERR != 0) begin : g_frac
        // err never reaches DENOMINATOR, so clog2(DENOMINATOR) bits suffice
        localparam int unsigned ERR_W = (DENOMINATOR > 1) ? $clog2(DENOMINATOR) : 1;
        localparam logic [ERR_W-1:0] THRESH = ERR_W'(DENOMINATOR - COUNT_ERR);
        localparam logic [ERR_W-1:0] INC    = ERR_W'(COUNT_ERR);

        logic [ERR_W-1:0] err_q;
        logic [ERR_W-1:0] err_d;
        logic             carry;

        assign carry = (err_q >= THRESH);
        assign err_d = carry ? (err_q - THRESH) : (err_q + INC);

        always_ff @(posedge clk) begin
            if (reset) begin
                err_q <= '0;
            end else begin
                err_q <= err_d;
            end
        end

        assign carry_o = carry;
    end else begin : g_integer
        logic unused_inputs;
        assign unused_inputs = &{1'b0, clk, reset};
        assign carry_o       = 1'b0;
    end

endmodule

`default_nettype wire

// File: rtl/jellyvl_synctimer_timer_slew.sv
// ============================================================================
//  Module      : jellyvl_synctimer_timer_slew
//  Description : Rational-rate free-running timer that slews signed
//                corrections in at most MAX_STEP per cycle, never backwards.
//                Option macro: JELLYVL_SYNCTIMER_SLEW_ABORT_EN (set aborts slew).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jellyvl_synctimer_timer_slew
    import jellyvl_synctimer_pkg::*;
#(
    parameter int unsigned NUMERATOR    = 10,
    parameter int unsigned DENOMINATOR  = 3,
    parameter int unsigned TIMER_WIDTH  = 64,
    parameter int unsigned ADJUST_WIDTH = 16,
    parameter int unsigned MAX_STEP     = 1
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    jellyvl_synctimer_timer_slew_if.slave bus
);
    localparam int unsigned COUNT_NUM = count_num(NUMERATOR, DENOMINATOR);
    localparam int unsigned INC_W_RAW = $clog2(COUNT_NUM + MAX_STEP + 2);
    localparam int unsigned INC_W     = (INC_W_RAW < 1) ? 1 : INC_W_RAW;
    localparam int unsigned MAG_W     = ADJUST_WIDTH + 1;

    if (DENOMINATOR == 0) begin : g_bad_denominator
        $error("DENOMINATOR must be at least 1");
    end
    if (MAX_STEP == 0 || MAX_STEP > COUNT_NUM) begin : g_bad_max_step
        $error("MAX_STEP must lie in 1..NUMERATOR/DENOMINATOR");
    end

    logic                           carry;
    logic        [INC_W-1:0]        base;
    slew_state_t                    state_q,       state_d;
    logic signed [ADJUST_WIDTH-1:0] pending_q,     pending_d;
    logic        [INC_W-1:0]        add_value_q,   add_value_d;
    logic        [TIMER_WIDTH-1:0]  current_time_q, current_time_d;
    logic signed [MAG_W-1:0]        pend_ext;
    logic        [MAG_W-1:0]        mag;
    logic        [INC_W-1:0]        step;

    jellyvl_synctimer_frac_step #(
        .NUMERATOR   (NUMERATOR),
        .DENOMINATOR (DENOMINATOR)
    ) u_frac_step (
        .clk     (clk),
        .reset   (reset),
        .carry_o (carry)
    );

    assign base = INC_W'(COUNT_NUM) + INC_W'(carry);

    // One extra bit so the most-negative request has a representable magnitude
    assign pend_ext = {pending_q[ADJUST_WIDTH-1], pending_q};
    assign mag      = pend_ext[MAG_W-1] ? $unsigned(-pend_ext) : $unsigned(pend_ext);
    assign step     = INC_W'(step_mag(64'(mag), 64'(MAX_STEP)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SLEW_IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        add_value_d = base;
        case (state_q)
            SLEW_IDLE: begin
                if (bus.adjust_valid) begin
                    pending_d = bus.adjust_value;
                    if (bus.adjust_value != '0) begin
                        state_d = SLEW_ACTIVE;
                    end
                end
            end
            SLEW_ACTIVE: begin
                // step never exceeds COUNT_NUM, so base - step cannot go negative
                if (pending_q[ADJUST_WIDTH-1]) begin
                    add_value_d = base - step;
                    pending_d   = pending_q + ADJUST_WIDTH'(step);
                end else begin
                    add_value_d = base + step;
                    pending_d   = pending_q - ADJUST_WIDTH'(step);
                end
                if (mag == MAG_W'(step)) begin
                    state_d = SLEW_IDLE;
                end
            end
            default: begin
                state_d   = SLEW_IDLE;
                pending_d = '0;
            end
        endcase
`ifdef JELLYVL_SYNCTIMER_SLEW_ABORT_EN
        if (bus.set_valid && state_q == SLEW_ACTIVE) begin
            state_d     = SLEW_IDLE;
            pending_d   = '0;
            add_value_d = base;
        end
`endif
    end

    assign current_time_d = (bus.set_valid ? bus.set_time : current_time_q)
                          + TIMER_WIDTH'(add_value_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            add_value_q    <= '0;
            current_time_q <= '0;
        end else begin
            add_value_q    <= add_value_d;
            current_time_q <= current_time_d;
        end
    end

    assign bus.adjust_ready  = (state_q == SLEW_IDLE);
    assign bus.adjust_busy   = (state_q != SLEW_IDLE);
    assign bus.adjust_remain = pending_q;
    assign bus.current_time  = current_time_q;

endmodule

`default_nettype wire

// File: tb/tb_jellyvl_synctimer_timer_slew.sv
// ============================================================================
//  Module      : tb_jellyvl_synctimer_timer_slew
//  Description : Bench for two timer instances (10/3 step 1, 30/3 step 2)
//                against a floor-arithmetic rate model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jellyvl_synctimer_timer_slew;

    typedef struct {
        longint unsigned t;
        longint          add;
        longint          p;
        longint          i;
    } mdl_t;

    typedef struct {
        logic signed [15:0] adj;
        int                 exp_busy;
        longint             exp_adv;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    mdl_t mA = '{default: 0};
    mdl_t mB = '{default: 0};

    jellyvl_synctimer_timer_slew_if #(.TIMER_WIDTH(64), .ADJUST_WIDTH(16)) ifA ();
    jellyvl_synctimer_timer_slew_if #(.TIMER_WIDTH(64), .ADJUST_WIDTH(16)) ifB ();

    jellyvl_synctimer_timer_slew #(
        .NUMERATOR(10), .DENOMINATOR(3), .TIMER_WIDTH(64), .ADJUST_WIDTH(16), .MAX_STEP(1)
    ) u_dut_a (.clk(clk), .reset(rst), .bus(ifA.slave));

    jellyvl_synctimer_timer_slew #(
        .NUMERATOR(30), .DENOMINATOR(3), .TIMER_WIDTH(64), .ADJUST_WIDTH(16), .MAX_STEP(2)
    ) u_dut_b (.clk(clk), .reset(rst), .bus(ifB.slave));

    always #5 clk = ~clk;

    // Base increment of cycle i is floor((i+1)N/D) - floor(iN/D); the
    // time register lags the decision by one cycle.
    function automatic mdl_t mdl_step(input mdl_t m, input longint n, input longint d,
                                      input longint mx, input bit r, input bit sv,
                                      input longint unsigned st, input bit av,
                                      input longint aval);
        mdl_t   o;
        longint base;
        longint stp;
        if (r) begin
            o = '{default: 0};
            return o;
        end
        base = ((m.i + 1) * n) / d - (m.i * n) / d;
        o.t   = (sv ? st : m.t) + longint'(m.add);
        o.add = base;
        o.p   = m.p;
        o.i   = m.i + 1;
        if (m.p != 0) begin
            stp = (m.p > 0) ? m.p : -m.p;
            if (stp > mx) stp = mx;
            if (m.p > 0) begin
                o.add = base + stp;
                o.p   = m.p - stp;
            end else begin
                o.add = base - stp;
                o.p   = m.p + stp;
            end
`ifdef JELLYVL_SYNCTIMER_SLEW_ABORT_EN
            if (sv) begin
                o.add = base;
                o.p   = 0;
            end
`endif
        end else if (av) begin
            o.p = aval;
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        mA = mdl_step(mA, 10, 3, 1, rst, ifA.set_valid, ifA.set_time,
                      ifA.adjust_valid, longint'(ifA.adjust_value));
        mB = mdl_step(mB, 30, 3, 2, rst, ifB.set_valid, ifB.set_time,
                      ifB.adjust_valid, longint'(ifB.adjust_value));
        @(posedge clk);
        #1;
        chk("timeA",   ifA.current_time, mA.t);
        chk("readyA",  64'(ifA.adjust_ready), 64'(mA.p == 0));
        chk("busyA",   64'(ifA.adjust_busy),  64'(mA.p != 0));
        chk("remainA", {48'd0, ifA.adjust_remain}, {48'd0, mA.p[15:0]});
        chk("timeB",   ifB.current_time, mB.t);
        chk("readyB",  64'(ifB.adjust_ready), 64'(mB.p == 0));
        chk("busyB",   64'(ifB.adjust_busy),  64'(mB.p != 0));
        chk("remainB", {48'd0, ifB.adjust_remain}, {48'd0, mB.p[15:0]});
    endtask

    initial begin
        vec_t               tab[5];
        logic [63:0]        t0;
        logic [63:0]        tp;
        longint             mininc;
        int                 busy;
        int                 r;
        logic signed [15:0] remB[5];
        logic [63:0]        cad[7];
        logic               rdy[6];

        tab[0] = '{adj:  16'sd5, exp_busy: 5, exp_adv: 55};
        tab[1] = '{adj: -16'sd3, exp_busy: 3, exp_adv: 47};
        tab[2] = '{adj:  16'sd0, exp_busy: 0, exp_adv: 50};
        tab[3] = '{adj:  16'sd1, exp_busy: 1, exp_adv: 51};
        tab[4] = '{adj: -16'sd6, exp_busy: 6, exp_adv: 44};
        remB   = '{-16'sd7, -16'sd5, -16'sd3, -16'sd1, 16'sd0};
        cad    = '{64'd0, 64'd3, 64'd6, 64'd10, 64'd13, 64'd16, 64'd20};
        rdy    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        ifA.set_time = '0; ifA.set_valid = 1'b0; ifA.adjust_value = '0; ifA.adjust_valid = 1'b0;
        ifB.set_time = '0; ifB.set_valid = 1'b0; ifB.adjust_value = '0; ifB.adjust_valid = 1'b0;

        // Reset state and post-reset cadence
        rst = 1'b1;
        tick(); tick();
        chk("rst_time",   ifA.current_time, 64'd0);
        chk("rst_ready",  64'(ifA.adjust_ready), 64'd1);
        chk("rst_remain", {48'd0, ifA.adjust_remain}, 64'd0);
        rst = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("cadenceA", ifA.current_time, cad[k]);
        end

        t0 = ifA.current_time;
        repeat (30) tick();
        chk("adv30A", ifA.current_time - t0, 64'd100);

        // Table: one-shot corrections over a 15-cycle window
        for (int k = 0; k < 5; k++) begin
            repeat (2) tick();
            t0   = ifA.current_time;
            busy = 0;
            ifA.adjust_valid = 1'b1;
            ifA.adjust_value = tab[k].adj;
            tick();
            ifA.adjust_valid = 1'b0;
            busy += int'(ifA.adjust_busy);
            repeat (14) begin
                tick();
                busy += int'(ifA.adjust_busy);
            end
            chk("tab_busy", 64'(busy), 64'(tab[k].exp_busy));
            chk("tab_adv",  ifA.current_time - t0, 64'(tab[k].exp_adv));
        end

        // Negative slew with MAX_STEP=2: steps 2,2,2,1 and no increment below 8
        t0 = ifB.current_time; tp = t0; mininc = 1000;
        ifB.adjust_valid = 1'b1; ifB.adjust_value = -16'sd7;
        for (int k = 0; k < 15; k++) begin
            tick();
            ifB.adjust_valid = 1'b0;
            if (k < 5) chk("remB_seq", {48'd0, ifB.adjust_remain}, {48'd0, remB[k]});
            if (longint'(ifB.current_time - tp) < mininc) mininc = longint'(ifB.current_time - tp);
            tp = ifB.current_time;
        end
        chk("minincB", 64'(mininc >= 8), 64'd1);
        chk("advB",    ifB.current_time - t0, 64'd143);

        // Load while idle
        tick();
        ifA.set_valid = 1'b1; ifA.set_time = 64'h1000;
        t0 = 64'h1000 + 64'(mA.add);
        tick();
        ifA.set_valid = 1'b0;
        chk("set_idle", ifA.current_time, t0);

        // Load in the middle of a slew
        ifA.adjust_valid = 1'b1; ifA.adjust_value = 16'sd5;
        tick();
        ifA.adjust_valid = 1'b0;
        tick();
        ifA.set_valid = 1'b1; ifA.set_time = 64'h2000;
        tick();
        ifA.set_valid = 1'b0;
`ifdef JELLYVL_SYNCTIMER_SLEW_ABORT_EN
        chk("set_slew_remain", {48'd0, ifA.adjust_remain}, 64'd0);
`else
        chk("set_slew_remain", {48'd0, ifA.adjust_remain}, 64'd3);
`endif
        repeat (8) tick();
        chk("set_slew_done", 64'(ifA.adjust_ready), 64'd1);

        // Valid held through a slew: re-accepted only once ready returns
        ifA.adjust_valid = 1'b1; ifA.adjust_value = 16'sd2;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("held_ready", 64'(ifA.adjust_ready), 64'(rdy[k]));
        end
        ifA.adjust_value = 16'sd0;
        repeat (2) tick();
        t0 = ifA.current_time;
        repeat (15) tick();
        chk("zero_adj_ready", 64'(ifA.adjust_ready), 64'd1);
        chk("zero_adj_adv",   ifA.current_time - t0, 64'd50);
        ifA.adjust_valid = 1'b0;

        // Wrap at 2^64
        rst = 1'b1; tick(); rst = 1'b0;
        ifA.set_valid = 1'b1; ifA.set_time = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        ifA.set_valid = 1'b0;
        chk("wrap_load", ifA.current_time, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        chk("wrap", ifA.current_time, 64'd1);

        // Most-negative request, then reset in the middle of both slews
        ifA.adjust_valid = 1'b1; ifA.adjust_value = 16'sd5;
        ifB.adjust_valid = 1'b1; ifB.adjust_value = 16'sh8000;
        tick();
        ifA.adjust_valid = 1'b0; ifB.adjust_valid = 1'b0;
        chk("minneg_load", {48'd0, ifB.adjust_remain}, 64'h8000);
        tick();
        chk("minneg_step", {48'd0, ifB.adjust_remain}, 64'h8002);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_timeB",  ifB.current_time, 64'd0);
        chk("midrst_busyA",  64'(ifA.adjust_busy), 64'd0);
        chk("midrst_remB",   {48'd0, ifB.adjust_remain}, 64'd0);
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("cadence_after_rst", ifA.current_time, cad[k]);
        end

        // Randomised traffic against the model
        for (int k = 0; k < 600; k++) begin
            ifA.set_valid    = ($urandom_range(19) == 0);
            ifA.set_time     = {$urandom, $urandom};
            ifA.adjust_valid = ($urandom_range(3) == 0);
            r = int'($urandom_range(40)) - 20;
            ifA.adjust_value = 16'(r);
            ifB.set_valid    = ($urandom_range(19) == 0);
            ifB.set_time     = {$urandom, $urandom};
            ifB.adjust_valid = ($urandom_range(3) == 0);
            r = int'($urandom_range(60)) - 30;
            ifB.adjust_value = 16'(r);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
